lfsr_encrypt_5a: RTL and testbench
==================================

// Module: lfsr_encrypt_5a
// PURPOSE
//  Programmable LFSR message encryptor. It is the upstream stage of top_level_5b.
//  It reads a plaintext message and three config bytes from data_mem, and prepends a
//  preamble of PAD_CHAR bytes. Each padded byte is XORed with a 6-bit maximal-length
//  LFSR state, and the 64 ciphertext bytes are written to data_mem[OUT_BASE +: 64],
//  which is the region top_level_5b decrypts.
// PARAMETERS
//  CFG_PRE_ADDR   61     data_mem address of preamble length byte
//  CFG_TAP_ADDR   62     data_mem address of tap-pattern select byte
//  CFG_SEED_ADDR  63     data_mem address of LFSR seed byte (bits [5:0] used)
//  OUT_BASE       64     first ciphertext write address
//  PAD_CHAR       8'h5f  preamble/padding character ('_')
// PORTS
//  clk       in   1  rising-edge clock
//  init      in   1  asynchronous active-high reset; operation starts when it falls
//  raddr     out  8  data_mem read address (combinational from state/counter)
//  data_out  in   8  data_mem read data; registered read, valid 1 clk after raddr
//  wr_en     out  1  data_mem write enable
//  waddr     out  8  data_mem write address
//  data_in   out  8  data_mem write data
//  done      out  1  encryption complete; held until init is asserted
// BEHAVIOUR
//  Reset (init=1, async): state=CFG_PRE, wr_en=0, done=0, waddr=0, data_in=0, raddr=61.
//  Tap table (fixed): sel0..5 = 6'h21,2D,30,33,36,39.
//  LFSR step: nxt = {cur[4:0],1'b0} + ^(cur & taps); 6-bit, truncate the shifted-out MSB.
//  FSM (one transition per clk while init=0):
//   CFG_PRE  : raddr=CFG_PRE_ADDR                                  -> CFG_TAP
//   CFG_TAP  : raddr=CFG_TAP_ADDR; latch pre=clamp(data_out)       -> CFG_SEED
//   CFG_SEED : raddr=CFG_SEED_ADDR; latch sel=data_out             -> LOAD
//   LOAD     : lfsr<=seed=data_out[5:0]; k<=0; raddr=0             -> RUN
//   RUN      : k=0..63, one byte per clk; at k==63 (after write)   -> DONE
//   DONE     : done=1, wr_en=0, no reads or writes; stays until init
//  Clamps: pre<7 -> 7, pre>12 -> 12; sel>5 -> 3 (6'h33); seed==0 -> 6'h01.
//  RUN cycle k:
//   - wr_en=1, waddr=OUT_BASE+k.
//   - data_in = ((k<pre) ? PAD_CHAR : data_out) ^ {2'b00,lfsr}.
//   - raddr = k+1-pre when k+1>=pre (else don't-care), so data_out holds mem[k-pre].
//   - lfsr advances one step at the end of the cycle.
//  Plaintext bytes are mem[0 .. 63-pre]; unused tail bytes are encrypted as stored.
//  Latency: done rises on the 69th rising clk after init falls (4 cfg + 64 RUN + 1).
//  Exactly 64 writes per run; no write outside [OUT_BASE, OUT_BASE+63].
//  The LFSR period is 63, so byte 63 uses the same LFSR state as byte 0.
//  Reset mid-operation: wr_en and done drop immediately (async). Partial ciphertext
//   stays in memory. The next run restarts from CFG_PRE and rewrites all 64 bytes.
//  init held high: no writes, no state advance.
// TESTING
//  1 pre=7, sel=2, seed=01, mem[0..56]=8'h40 -> mem[64..70]=5e 5d 5b 57 4f 7e 5c,
//    mem[71]=46; done exactly 69 clks after init falls.
//  2 pre=3, sel=7, seed=00 -> output identical to the run with pre=7, sel=3, seed=01;
//    pre=20 -> output identical to the run with pre=12.
//  3 init reasserted at RUN k=20 -> wr_en=0 in the same cycle, no further writes;
//    release -> full 64-byte rerun matches the golden model.
//  4 pre=12, sel=5, seed=3F -> mem[64]=5f^3f=60; mem[127] encrypted with seed 3F;
//    bytes 64..75 all pad^lfsr.
//  5 After done: hold init=0 for 50 clks -> done stays 1, wr_en stays 0, memory unchanged.
//  6 Round trip: run the msg "@@@@@@@@@@``````````" (x2.5), then top_level_5b
//    -> decrypted mem[0..49] == original, fault_count=0.

Source files
------------

// File: rtl/lfsr_encrypt_5a_if.sv
// Memory-side bus of the LFSR encryptor: one registered read port, one write port, done flag.
interface lfsr_encrypt_5a_if;
    logic [7:0] raddr;
    logic [7:0] data_out;
    logic       wr_en;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       done;

    modport master (output raddr, wr_en, waddr, data_in, done, input data_out);
    modport slave  (input raddr, wr_en, waddr, data_in, done, output data_out);
endinterface

// File: rtl/lfsr_encrypt_5a.sv
// Programmable 6-bit LFSR encryptor: reads config + plaintext from data_mem, prepends a
// PAD_CHAR preamble and writes 64 XOR-ciphered bytes starting at OUT_BASE.
module lfsr_encrypt_5a #(
    parameter int          CFG_PRE_ADDR  = 61,
    parameter int          CFG_TAP_ADDR  = 62,
    parameter int          CFG_SEED_ADDR = 63,
    parameter int          OUT_BASE      = 64,
    parameter logic [7:0]  PAD_CHAR      = 8'h5f
) (
    input  logic              clk,
    input  logic              init,
    lfsr_encrypt_5a_if.master bus
);

    typedef enum logic [2:0] {CFG_PRE, CFG_TAP, CFG_SEED, LOAD, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] pre;
    logic [2:0] sel;
    logic [5:0] lfsr;
    logic [5:0] k;
    logic       done_q;
    logic [7:0] k8;

    function automatic logic [5:0] tap_of(input logic [2:0] s);
        case (s)
            3'd0:    tap_of = 6'h21;
            3'd1:    tap_of = 6'h2d;
            3'd2:    tap_of = 6'h30;
            3'd3:    tap_of = 6'h33;
            3'd4:    tap_of = 6'h36;
            default: tap_of = 6'h39;
        endcase
    endfunction

    // Shift left, feedback parity lands in the vacated LSB; MSB falls off.
    function automatic logic [5:0] lfsr_step(input logic [5:0] cur, input logic [5:0] taps);
        lfsr_step = {cur[4:0], 1'b0} + {5'b0, ^(cur & taps)};
    endfunction

    assign k8 = {2'b00, k};

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state  <= CFG_PRE;
            pre    <= 4'd7;
            sel    <= 3'd0;
            lfsr   <= 6'h01;
            k      <= 6'd0;
            done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                CFG_TAP: begin
                    if (bus.data_out < 8'd7)       pre <= 4'd7;
                    else if (bus.data_out > 8'd12) pre <= 4'd12;
                    else                           pre <= bus.data_out[3:0];
                end
                CFG_SEED: sel <= (bus.data_out > 8'd5) ? 3'd3 : bus.data_out[2:0];
                LOAD: begin
                    // An all-zero seed would lock the LFSR at zero.
                    lfsr <= (bus.data_out[5:0] == 6'h00) ? 6'h01 : bus.data_out[5:0];
                    k    <= 6'd0;
                end
                RUN: begin
                    lfsr <= lfsr_step(lfsr, tap_of(sel));
                    k    <= k + 6'd1;
                end
                DONE:    done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.raddr   = 8'd0;
        bus.wr_en   = 1'b0;
        bus.waddr   = 8'd0;
        bus.data_in = 8'd0;
        case (state)
            CFG_PRE: begin
                bus.raddr = 8'(CFG_PRE_ADDR);
                state_nxt = CFG_TAP;
            end
            CFG_TAP: begin
                bus.raddr = 8'(CFG_TAP_ADDR);
                state_nxt = CFG_SEED;
            end
            CFG_SEED: begin
                bus.raddr = 8'(CFG_SEED_ADDR);
                state_nxt = LOAD;
            end
            LOAD: begin
                bus.raddr = 8'd0;
                state_nxt = RUN;
            end
            RUN: begin
                // Read one byte ahead so the registered read lines up with k+1.
                if (k8 + 8'd1 >= {4'b0, pre})
                    bus.raddr = k8 + 8'd1 - {4'b0, pre};
                bus.wr_en   = 1'b1;
                bus.waddr   = 8'(OUT_BASE) + k8;
                bus.data_in = ((k8 < {4'b0, pre}) ? PAD_CHAR : bus.data_out) ^ {2'b00, lfsr};
                if (k == 6'd63) state_nxt = DONE;
            end
            default: state_nxt = DONE;
        endcase
    end

    assign bus.done = done_q;

endmodule

// File: tb/tb_lfsr_encrypt_5a.sv
// Scoreboard bench for lfsr_encrypt_5a: a behavioural data_mem, a reference encryptor
// filling an expected-write queue, and a write monitor that pops and compares.
module tb_lfsr_encrypt_5a;

    logic clk = 1'b0;
    logic init = 1'b1;
    lfsr_encrypt_5a_if bus ();

    lfsr_encrypt_5a dut (.clk(clk), .init(init), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic [7:0] mem [0:255];
    logic [7:0] img [0:255];
    logic [7:0] saved [0:63];
    logic       ld = 1'b0;
    wr_t        exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.wr_en) begin
            mem[bus.waddr] <= bus.data_in;
        end
        bus.data_out <= mem[bus.raddr];
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_t e;
            n_wr++;
            chk("sb_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("waddr", bus.waddr, e.addr);
                chk("wdata", bus.data_in, e.data);
            end
        end
    end

    function automatic logic [5:0] taps_for(input int s);
        logic [5:0] t [0:5];
        t = '{6'h21, 6'h2d, 6'h30, 6'h33, 6'h36, 6'h39};
        return t[s];
    endfunction

    // Reference encryptor driven from the raw config bytes, clamping done here.
    task automatic push_exp(input int pre_raw, input int sel_raw, input int seed_raw);
        int pre, s;
        logic [5:0] l, t;
        logic [7:0] pt;
        pre = (pre_raw < 7) ? 7 : (pre_raw > 12) ? 12 : pre_raw;
        s   = (sel_raw > 5) ? 3 : sel_raw;
        l   = (seed_raw[5:0] == 6'd0) ? 6'h01 : seed_raw[5:0];
        t   = taps_for(s);
        for (int k = 0; k < 64; k++) begin
            pt = (k < pre) ? 8'h5f : img[k - pre];
            exp_q.push_back('{addr: 8'(64 + k), data: pt ^ {2'b00, l}});
            l = {l[4:0], ^(l & t)};
        end
    endtask

    task automatic load_cfg(input int pre_raw, input int sel_raw, input int seed_raw);
        img[61] = 8'(pre_raw);
        img[62] = 8'(sel_raw);
        img[63] = 8'(seed_raw);
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic full_run(input string tag, input int pre_raw, input int sel_raw, input int seed_raw);
        int cyc;
        load_cfg(pre_raw, sel_raw, seed_raw);
        push_exp(pre_raw, sel_raw, seed_raw);
        n_wr = 0;
        @(negedge clk) init = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({tag, "_latency"}, cyc, 69);
        @(negedge clk);
        chk({tag, "_nwr"}, n_wr, 64);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic end_run;
        @(negedge clk) init = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] g1 [0:7];
        logic [5:0] l;
        g1 = '{8'h5e, 8'h5d, 8'h5b, 8'h57, 8'h4f, 8'h7e, 8'h5c, 8'h46};
        for (int i = 0; i < 256; i++) img[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_raddr", bus.raddr, 8'd61);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_data_in", bus.data_in, 0);

        // 1: known vectors
        for (int i = 0; i < 57; i++) img[i] = 8'h40;
        full_run("t1", 7, 2, 1);
        for (int i = 0; i < 8; i++) chk("t1_gold", mem[64 + i], g1[i]);

        // 5: idle after done
        for (int i = 0; i < 64; i++) saved[i] = mem[64 + i];
        n_wr = 0;
        repeat (50) begin
            @(negedge clk);
            chk("t5_done", bus.done, 1);
            chk("t5_wr_en", bus.wr_en, 0);
        end
        chk("t5_nwr", n_wr, 0);
        for (int i = 0; i < 64; i++) chk("t5_mem", mem[64 + i], saved[i]);
        end_run();
        chk("t5_done_clr", bus.done, 0);

        // 2: clamps
        for (int i = 0; i < 61; i++) img[i] = 8'($urandom_range(0, 255));
        full_run("t2a", 3, 7, 0);
        end_run();
        for (int i = 0; i < 64; i++) saved[i] = mem[64 + i];
        full_run("t2b", 7, 3, 1);
        end_run();
        for (int i = 0; i < 64; i++) chk("t2_same_lo", mem[64 + i], saved[i]);
        full_run("t2c", 20, 1, 9);
        end_run();
        for (int i = 0; i < 64; i++) saved[i] = mem[64 + i];
        full_run("t2d", 12, 1, 9);
        end_run();
        for (int i = 0; i < 64; i++) chk("t2_same_hi", mem[64 + i], saved[i]);

        // 3: abort at k=20 then rerun
        load_cfg(9, 4, 8'h2a);
        push_exp(9, 4, 8'h2a);
        n_wr = 0;
        @(negedge clk) init = 1'b0;
        repeat (24) @(posedge clk);
        #1 init = 1'b1;
        #1 chk("t3_wr_en", bus.wr_en, 0);
        chk("t3_done", bus.done, 0);
        chk("t3_nwr", n_wr, 20);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("t3_hold_nwr", n_wr, 20);
        full_run("t3r", 9, 4, 8'h2a);
        end_run();

        // 4: long preamble, seed 3F
        full_run("t4", 12, 5, 8'h3f);
        chk("t4_first", mem[64], 8'h60);
        chk("t4_last", mem[127], img[51] ^ 8'h3f);
        end_run();

        // 6: round trip of the message through an independent decrypt
        for (int i = 0; i < 50; i++) img[i] = (i % 20 < 10) ? 8'h40 : 8'h60;
        full_run("t6", 8, 1, 8'h15);
        l = 6'h15;
        for (int k = 0; k < 64; k++) begin
            if (k >= 8 && k - 8 < 50) chk("t6_rt", mem[64 + k] ^ {2'b00, l}, img[k - 8]);
            l = {l[4:0], ^(l & 6'h2d)};
        end
        end_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
